// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch
//  Purpose  : Front-end fetch stage. Holds the program counter, issues
//             sequential word requests to the instruction cache, buffers
//             in-order responses in a small instruction queue and presents
//             the queue head to decode. Redirects flush the queue, restart
//             the PC and discard responses that were already in flight.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1  clock, rising edge
//    reset           in   1  synchronous active-high reset
//    redirect_valid  in   1  restart fetch at redirect_pc and flush
//    redirect_pc     in  32  new fetch address (bits [1:0] ignored)
//    ic_req_valid    out  1  fetch request valid
//    ic_req_addr     out 32  word-aligned request address (current PC)
//    ic_req_ready    in   1  icache accepts the request this cycle
//    ic_rsp_valid    in   1  response valid (in request order)
//    ic_rsp_data     in  32  instruction word
//    stall_de0       in   1  decode cannot accept this cycle
//    valid_fe1       out  1  instr_fe1 / pc_fe1 valid
//    instr_fe1       out 32  queue-head instruction
//    pc_fe1          out 32  PC of instr_fe1
// ============================================================================
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_req_ready,
    input  logic        ic_rsp_valid,
    input  logic [31:0] ic_rsp_data,
    input  logic        stall_de0,
    output logic        valid_fe1,
    output logic [31:0] instr_fe1,
    output logic [31:0] pc_fe1
);

    // Pointer width and counter width (counters must hold 0..QDEPTH).
    localparam int                c_PW        = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int                c_CW        = c_PW + 1;
    localparam logic [c_CW:0]     c_QDEPTH_S  = (c_CW + 1)'(QDEPTH);
    localparam logic [c_CW-1:0]   c_CNT_ONE   = c_CW'(1);
    localparam logic [c_CW-1:0]   c_CNT_ZERO  = '0;
    localparam logic [c_PW-1:0]   c_PTR_ONE   = c_PW'(1);

    logic [31:0]      r_pc;
    logic [31:0]      r_rsp_pc;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  r_outstanding;
    logic [c_CW-1:0]  r_drop_cnt;
    logic [c_PW-1:0]  r_head;
    logic [c_PW-1:0]  r_tail;
    logic [31:0]      r_q_instr [QDEPTH];
    logic [31:0]      r_q_pc    [QDEPTH];

    logic [c_CW:0]    w_credit_used;
    logic             w_can_issue;
    logic             w_accept;
    logic             w_rsp_keep;
    logic             w_deq;
    logic [31:0]      w_redirect_pc;
    logic [c_CW-1:0]  w_acc_inc;
    logic [c_CW-1:0]  w_rsp_dec;

    // Credit counts only registered occupancy; a same-cycle dequeue does
    // not free a slot. This reserves a queue entry for every request that
    // may still return a non-stale response, so the queue cannot overflow.
    assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_can_issue   = (w_credit_used < c_QDEPTH_S);

    assign ic_req_valid  = w_can_issue && !redirect_valid && !reset;
    assign ic_req_addr   = r_pc;
    assign w_accept      = ic_req_valid && ic_req_ready;

    // A response is kept only when it is not owed to a discarded stream and
    // no redirect is flushing the queue in the same cycle.
    assign w_rsp_keep    = ic_rsp_valid && (r_drop_cnt == c_CNT_ZERO) && !redirect_valid;

    assign valid_fe1     = (r_count != c_CNT_ZERO) && !redirect_valid;
    assign instr_fe1     = r_q_instr[r_head];
    assign pc_fe1        = r_q_pc[r_head];
    assign w_deq         = valid_fe1 && !stall_de0;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_acc_inc     = w_accept     ? c_CNT_ONE : c_CNT_ZERO;
    assign w_rsp_dec     = ic_rsp_valid ? c_CNT_ONE : c_CNT_ZERO;

    // Program counter and the PC tag tracking the next kept response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_pc;
            r_rsp_pc <= w_redirect_pc;
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_rsp_keep) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
        end
    end

    // In-flight request tracking. Outstanding keeps counting through a
    // redirect because the icache still owes those responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= c_CNT_ZERO;
            r_drop_cnt    <= c_CNT_ZERO;
        end else begin
            r_outstanding <= r_outstanding + w_acc_inc - w_rsp_dec;
            if (redirect_valid) begin
                // A response arriving in the redirect cycle is already
                // discarded, so it is not counted as stale.
                r_drop_cnt <= r_outstanding - w_rsp_dec;
            end else if (ic_rsp_valid && (r_drop_cnt != c_CNT_ZERO)) begin
                r_drop_cnt <= r_drop_cnt - c_CNT_ONE;
            end
        end
    end

    // Queue control.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_count <= c_CNT_ZERO;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            if (w_rsp_keep) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_deq) begin
                r_head <= r_head + c_PTR_ONE;
            end
            if (w_rsp_keep && !w_deq) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_rsp_keep && w_deq) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Queue storage is not reset; entries are only read while valid.
    always_ff @(posedge clk) begin
        if (w_rsp_keep && !reset) begin
            r_q_instr[r_tail] <= ic_rsp_data;
            r_q_pc[r_tail]    <= r_rsp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch
//  Purpose  : Directed self-checking bench for the fetch stage, driving a
//             small fixed-latency icache model and logging what decode sees.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] c_XOR      = 32'h5A5A_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_data;
    logic        stall_de0;
    logic        valid_fe1;
    logic [31:0] instr_fe1;
    logic [31:0] pc_fe1;

    fetch #(
        .RESET_PC (c_RESET_PC),
        .QDEPTH   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_ready   (ic_req_ready),
        .ic_rsp_valid   (ic_rsp_valid),
        .ic_rsp_data    (ic_rsp_data),
        .stall_de0      (stall_de0),
        .valid_fe1      (valid_fe1),
        .instr_fe1      (instr_fe1),
        .pc_fe1         (pc_fe1)
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } dec_t;

    req_t pend[$];
    dec_t dlog[$];

    int cyc      = 0;
    int lat      = 1;
    int n_err    = 0;
    int n_chk    = 0;
    int nv       = 0;
    int found    = 0;
    int k        = 0;
    int exp_drop = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Everything decode consumed must be a contiguous word stream from
    // start, each instruction being the icache word for its PC.
    task automatic verify_log(input string tag, input logic [31:0] start, input int min_len);
        int          bad;
        logic [31:0] p;
        bad = 0;
        p   = start;
        foreach (dlog[i]) begin
            if (dlog[i].pc !== p || dlog[i].instr !== (p ^ c_XOR)) bad++;
            p = p + 32'd4;
        end
        check({tag, "_order"}, 32'(bad), 32'd0);
        check({tag, "_len"}, (dlog.size() >= min_len) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Icache model: fixed latency, in order, data = addr ^ c_XOR.
    initial begin
        ic_rsp_valid = 1'b0;
        ic_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (reset) begin
                pend.delete();
                ic_rsp_valid = 1'b0;
                ic_rsp_data  = 32'h0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                ic_rsp_valid = 1'b1;
                ic_rsp_data  = pend[0].addr ^ c_XOR;
                void'(pend.pop_front());
            end else begin
                ic_rsp_valid = 1'b0;
                ic_rsp_data  = 32'h0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && ic_req_valid && ic_req_ready)
                pend.push_back('{ic_req_addr, cyc + lat});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && valid_fe1 && !stall_de0)
                dlog.push_back('{pc_fe1, instr_fe1});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ic_req_ready   = 1'b1;
        stall_de0      = 1'b0;

        // ---- reset and sequential fetch ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(ic_req_valid), 32'd0);
        check("rst_valid_fe1", 32'(valid_fe1), 32'd0);

        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("c0_req_valid", 32'(ic_req_valid), 32'd1);
        check("c0_req_addr", ic_req_addr, 32'h100);
        check("c0_valid_fe1", 32'(valid_fe1), 32'd0);
        @(negedge clk);
        check("c1_valid_fe1", 32'(valid_fe1), 32'd0);
        check("c1_req_addr", ic_req_addr, 32'h104);
        @(negedge clk);
        check("c2_valid_fe1", 32'(valid_fe1), 32'd1);
        check("c2_pc_fe1", pc_fe1, 32'h100);
        check("c2_instr_fe1", instr_fe1, 32'h100 ^ c_XOR);
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_fe1) nv++;
        end
        check("stream_valid_cycles", 32'(nv), 32'd6);

        // ---- backpressure ----
        @(posedge clk); #1; stall_de0 = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_count", 32'(dut.r_count), 32'd4);
        check("bp_outstanding", 32'(dut.r_outstanding), 32'd0);
        check("bp_req_valid", 32'(ic_req_valid), 32'd0);
        @(posedge clk); #1; stall_de0 = 1'b0;
        @(negedge clk);
        check("bp_rel_req_valid", 32'(ic_req_valid), 32'd0);
        check("bp_rel_valid_fe1", 32'(valid_fe1), 32'd1);
        @(negedge clk);
        check("bp_reassert", 32'(ic_req_valid), 32'd1);
        repeat (6) @(negedge clk);
        @(posedge clk); #1; ic_req_ready = 1'b0;
        repeat (8) @(negedge clk);
        verify_log("seq", 32'h100, 15);

        // ---- redirect with two stale responses in flight ----
        @(posedge clk); #1; lat = 3; ic_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h2002; dlog.delete();
        @(negedge clk);
        check("rd_req_valid", 32'(ic_req_valid), 32'd0);
        check("rd_valid_fe1", 32'(valid_fe1), 32'd0);
        check("rd_outstanding", 32'(dut.r_outstanding), 32'd2);
        @(posedge clk); #1; redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_new_req_valid", 32'(ic_req_valid), 32'd1);
        check("rd_new_addr", ic_req_addr, 32'h2000);
        check("rd_drop_cnt", 32'(dut.r_drop_cnt), 32'd2);
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid_fe1) nv++;
        end
        check("rd_stale_hidden", 32'(nv), 32'd0);
        check("rd_drop_zero", 32'(dut.r_drop_cnt), 32'd0);
        @(negedge clk);
        check("rd_first_valid", 32'(valid_fe1), 32'd1);
        check("rd_first_pc", pc_fe1, 32'h2000);
        check("rd_first_instr", instr_fe1, 32'h2000 ^ c_XOR);

        // ---- redirect coinciding with a response and a stall ----
        @(posedge clk); #1; stall_de0 = 1'b1;
        found = 0;
        k     = 0;
        while (found == 0 && k < 20) begin
            @(negedge clk);
            k++;
            if (valid_fe1 && pend.size() > 0 && pend[0].due == cyc + 1) found = 1;
        end
        check("co_setup_found", 32'(found), 32'd1);
        verify_log("rd", 32'h2000, 1);
        @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h3000; dlog.delete();
        @(negedge clk);
        exp_drop = pend.size();
        check("co_valid_fe1", 32'(valid_fe1), 32'd0);
        @(posedge clk); #1; redirect_valid = 1'b0; stall_de0 = 1'b0;
        @(negedge clk);
        check("co_count", 32'(dut.r_count), 32'd0);
        check("co_valid_next", 32'(valid_fe1), 32'd0);
        check("co_drop_cnt", 32'(dut.r_drop_cnt), 32'(exp_drop));

        // ---- back-to-back redirects ----
        @(posedge clk); #1;
        @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(posedge clk); #1; redirect_pc = 32'h400;
        @(negedge clk);
        exp_drop = pend.size();
        check("b2b_first_pc", ic_req_addr, 32'h300);
        @(posedge clk); #1; redirect_valid = 1'b0; dlog.delete();
        @(negedge clk);
        check("b2b_drop_cnt", 32'(dut.r_drop_cnt), 32'(exp_drop));
        check("b2b_addr", ic_req_addr, 32'h400);
        check("b2b_req_valid", 32'(ic_req_valid), 32'd1);
        repeat (20) @(negedge clk);
        check("b2b_drop_zero", 32'(dut.r_drop_cnt), 32'd0);
        verify_log("b2b", 32'h400, 5);

        // ---- PC wrap ----
        @(posedge clk); #1; lat = 1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1; redirect_valid = 1'b0; dlog.delete();
        @(negedge clk);
        check("wrap_req_valid", 32'(ic_req_valid), 32'd1);
        check("wrap_addr0", ic_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_addr1", ic_req_addr, 32'h0000_0000);
        repeat (15) @(negedge clk);
        verify_log("wrap", 32'hFFFF_FFFC, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
